mem_calc_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the 4x16 calculator result memory (mem_calc).

---
 rtl/mem_calc_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_calc_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_calc_ctrl.sv
// Sequencer/arbiter sharing the single port of the 4x16 calculator result
// memory between a write requester and a read requester (round-robin).
// Tracks which locations hold valid results; unwritten ones read back as 0.
module mem_calc_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FUNC_W  = 3,
  parameter int unsigned NUM_LOC = 4,
  localparam int unsigned ADDR_W = $clog2(NUM_LOC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [FUNC_W-1:0] wr_func,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  output logic [NUM_LOC-1:0] valid_map,
  output logic              busy,
  output logic [FUNC_W-1:0] mem_sel_func,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WR_ERR = 3'd2,
    S_RD     = 3'd3,
    S_RD_CAP = 3'd4,
    S_RD_DONE= 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;   // 1 = last grant went to write
  logic [NUM_LOC-1:0]  valid_map_q, valid_map_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_hit_q, rd_hit_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic [FUNC_W-1:0]   mem_sel_func_q, mem_sel_func_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                func_legal_c;

  // Legal write codes map one-to-one onto locations 1..NUM_LOC
  assign func_legal_c = (wr_func != '0) && (wr_func <= FUNC_W'(NUM_LOC));

  // Next state, bookkeeping, and next values of the registered outputs
  always_comb begin
    state_d        = state_q;
    last_wr_d      = last_wr_q;
    valid_map_d    = valid_map_q;
    rd_data_d      = rd_data_q;
    rd_hit_d       = rd_hit_q;
    wr_ack_d       = 1'b0;
    wr_err_d       = 1'b0;
    rd_valid_d     = 1'b0;
    mem_sel_func_d = '0;
    mem_addr_d     = '0;
    mem_din_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (wr_req && (!rd_req || !last_wr_q)) begin
          last_wr_d = 1'b1;
          state_d   = func_legal_c ? S_WR : S_WR_ERR;
        end else if (rd_req) begin
          last_wr_d = 1'b0;
          state_d   = S_RD;
        end
      end
      S_WR: begin
        valid_map_d[mem_addr_q] = 1'b1;
        state_d = S_IDLE;
      end
      S_WR_ERR: state_d = S_IDLE;
      S_RD:     state_d = S_RD_CAP;
      S_RD_CAP: begin
        rd_hit_d  = valid_map_q[mem_addr_q];
        rd_data_d = valid_map_q[mem_addr_q] ? mem_dout : '0;
        state_d   = S_RD_DONE;
      end
      S_RD_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered, so they register with it
    case (state_d)
      S_WR: begin
        mem_sel_func_d = wr_func;
        mem_addr_d     = ADDR_W'(wr_func - FUNC_W'(1));
        mem_din_d      = wr_data;
        wr_ack_d       = 1'b1;
      end
      S_WR_ERR: begin
        wr_ack_d = 1'b1;
        wr_err_d = 1'b1;
      end
      S_RD:      mem_addr_d = rd_addr;
      S_RD_CAP:  mem_addr_d = mem_addr_q;
      S_RD_DONE: rd_valid_d = 1'b1;
      default:   ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_wr_q      <= 1'b0;
      valid_map_q    <= '0;
      rd_data_q      <= '0;
      rd_hit_q       <= 1'b0;
      wr_ack_q       <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      mem_sel_func_q <= '0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
    end else begin
      state_q        <= state_d;
      last_wr_q      <= last_wr_d;
      valid_map_q    <= valid_map_d;
      rd_data_q      <= rd_data_d;
      rd_hit_q       <= rd_hit_d;
      wr_ack_q       <= wr_ack_d;
      wr_err_q       <= wr_err_d;
      rd_valid_q     <= rd_valid_d;
      busy_q         <= busy_d;
      mem_sel_func_q <= mem_sel_func_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_hit       = rd_hit_q;
  assign valid_map    = valid_map_q;
  assign busy         = busy_q;
  assign mem_sel_func = mem_sel_func_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_mem_calc_ctrl.sv
// Directed testbench for mem_calc_ctrl with a behavioural 4x16 result memory.
module tb_mem_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req;
  logic [2:0]  wr_func;
  logic [15:0] wr_data;
  logic        wr_ack, wr_err;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic [3:0]  valid_map;
  logic        busy;
  logic [2:0]  mem_sel_func;
  logic [1:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [15:0] tb_mem [4];

  mem_calc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_func(wr_func), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit),
    .valid_map(valid_map), .busy(busy),
    .mem_sel_func(mem_sel_func), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Result memory: nonzero sel_func writes, otherwise registered read
  always @(posedge clk) begin
    if (mem_sel_func != 3'd0) tb_mem[mem_addr] <= mem_din;
    else                      mem_dout <= tb_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] func, input logic [15:0] data,
                          input logic exp_err, input logic [2:0] exp_sel,
                          input logic [1:0] exp_addr);
    int lat = 0;
    logic got = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_func = func; wr_data = data;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (wr_ack) got = 1'b1;
    end
    chk("wr_ack_seen", 32'(got), 32'd1);
    chk("wr_latency", 32'(lat), 32'd1);
    chk("wr_err", 32'(wr_err), 32'(exp_err));
    chk("wr_sel_func", 32'(mem_sel_func), 32'(exp_sel));
    if (!exp_err) begin
      chk("wr_mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("wr_mem_din", 32'(mem_din), 32'(data));
    end
    chk("wr_busy", 32'(busy), 32'd1);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", 32'(wr_ack), 32'd0);
    chk("wr_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic exp_hit, input logic [15:0] exp_data);
    int lat = 0;
    logic got = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = addr;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rd_valid) got = 1'b1;
    end
    chk("rd_valid_seen", 32'(got), 32'd1);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_hit", 32'(rd_hit), 32'(exp_hit));
    chk("rd_data", 32'(rd_data), 32'(exp_data));
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_data_held", 32'(rd_data), 32'(exp_data));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_ev;
    int  n_same;
    int  n_both;
    logic first_w;
    logic prev_w;
    logic done;

    for (int i = 0; i < 4; i++) tb_mem[i] = 16'hDEAD;
    rst_n = 1'b0; wr_req = 1'b0; wr_func = 3'd0; wr_data = 16'h0;
    rd_req = 1'b0; rd_addr = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid_map", 32'(valid_map), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_hit", 32'(rd_hit), 32'd0);
    chk("rst_pulses", 32'({wr_ack, wr_err, rd_valid}), 32'd0);
    chk("rst_sel_func", 32'(mem_sel_func), 32'd0);
    rst_n = 1'b1;

    // T1: unwritten location reads back 0 even though memory holds junk
    do_read(2'd2, 1'b0, 16'h0000);

    // T2: write func 3, then read it back
    do_write(3'd3, 16'hBEEF, 1'b0, 3'd3, 2'd2);
    chk("t2_valid_map", 32'(valid_map), 32'h4);
    do_read(2'd2, 1'b1, 16'hBEEF);

    // T3: illegal codes are rejected without touching memory or valid_map
    do_write(3'd6, 16'h1111, 1'b1, 3'd0, 2'd0);
    chk("t3_valid_map", 32'(valid_map), 32'h4);
    do_write(3'd0, 16'h2222, 1'b1, 3'd0, 2'd0);
    do_write(3'd5, 16'h3333, 1'b1, 3'd0, 2'd0);
    chk("t3_valid_map2", 32'(valid_map), 32'h4);

    // T5: overwrite a valid location
    do_write(3'd1, 16'h1234, 1'b0, 3'd1, 2'd0);
    do_write(3'd1, 16'h5678, 1'b0, 3'd1, 2'd0);
    chk("t5_valid_map", 32'(valid_map), 32'h5);
    do_read(2'd0, 1'b1, 16'h5678);
    do_read(2'd1, 1'b0, 16'h0000);

    // T6: reset during a write
    @(negedge clk);
    wr_req = 1'b1; wr_func = 3'd4; wr_data = 16'hAAAA;
    @(negedge clk);
    chk("t6_wr_ack", 32'(wr_ack), 32'd1);
    chk("t6_sel_func", 32'(mem_sel_func), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid_map", 32'(valid_map), 32'd0);
    chk("t6_wr_ack_clr", 32'(wr_ack), 32'd0);
    chk("t6_rd_data_clr", 32'(rd_data), 32'd0);
    chk("t6_mem_written", 32'(tb_mem[3]), 32'hAAAA);
    rst_n = 1'b1; wr_req = 1'b0;
    do_read(2'd3, 1'b0, 16'h0000);

    // T4: both requests held from reset -> strict W,R,W,R alternation
    @(negedge clk);
    rst_n = 1'b0;
    wr_req = 1'b1; wr_func = 3'd2; wr_data = 16'h1111;
    rd_req = 1'b1; rd_addr = 2'd1;
    @(negedge clk);
    rst_n = 1'b1;
    n_ev = 0; n_same = 0; n_both = 0; first_w = 1'b0; prev_w = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wr_ack && rd_valid) n_both++;
      if (wr_ack || rd_valid) begin
        if (n_ev == 0) first_w = wr_ack;
        else if (prev_w == wr_ack) n_same++;
        prev_w = wr_ack;
        n_ev++;
        if (rd_valid) begin
          chk("t4_rd_data", 32'(rd_data), 32'h1111);
          chk("t4_rd_hit", 32'(rd_hit), 32'd1);
        end
      end
    end
    chk("t4_first_write", 32'(first_w), 32'd1);
    chk("t4_no_repeat", 32'(n_same), 32'd0);
    chk("t4_no_overlap", 32'(n_both), 32'd0);
    chk("t4_event_count", 32'(n_ev >= 12), 32'd1);
    wr_req = 1'b0; rd_req = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("t4_drain", 32'(done), 32'd1);
    chk("t4_valid_map", 32'(valid_map), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
